// File: rtl/load_scoreboard_pkg.sv
// Shared register-file constants for the scoreboard, forwarding and decode.
// No logic: constants and types only.
// No flow control.
package load_scoreboard_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/load_scoreboard_sb_addr_fifo.sv
// In-order FIFO of destination register addresses for outstanding ops.
// Push/pop take effect at the next edge; head is the registered oldest entry.
// No internal guarding: the caller only pushes when not full (or popping) and pops when non-empty.
module sb_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage needs no reset: occupancy, not contents, defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/load_scoreboard.sv
// Scoreboard of destination registers for in-flight variable-latency ops; raises stall on use.
// stall is combinational from registered counters; updates land at the next edge.
// issue_ready drops when DEPTH ops are outstanding unless a completion frees a slot this cycle.
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  complete_valid,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs2_used,
  output logic                  stall,
  output logic [CNT_W-1:0]      pending_count,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  err_underflow
);

  logic                  issue_fire;
  logic                  pop;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;
  logic [CNT_W-1:0]      cnt [NUM_REGS];

  // A same-cycle completion always has something to pop when the FIFO is full.
  assign issue_ready = (pending_count != CNT_W'(DEPTH)) || complete_valid;
  assign issue_fire  = issue_valid && issue_ready;
  assign pop         = complete_valid && (pending_count != '0);

  // x0 still goes through the FIFO so later completions map to the right register.
  sb_addr_fifo #(
    .DEPTH (DEPTH),
    .W     (REG_ADDR_W),
    .CW    (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .arst_n   (arst_n),
    .push     (issue_fire),
    .push_dat (issue_rd),
    .pop      (pop),
    .head     (head_rd),
    .count    (pending_count)
  );

  // Decode per-register increment/decrement requests; x0 is never tracked.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_fire && (issue_rd != ZERO_REG)) inc_vec[issue_rd] = 1'b1;
    if (pop && (head_rd != ZERO_REG))         dec_vec[head_rd]  = 1'b1;
  end

  // Pending-write counters; a simultaneous issue and completion of one register cancel.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   cnt[r] <= cnt[r] + CNT_W'(1);
          2'b01:   cnt[r] <= cnt[r] - CNT_W'(1);
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

  // A register is busy while any write to it is outstanding.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_vec[r] = (cnt[r] != '0);
  end

  // Stall only for sources actually read and not hard-wired to zero.
  always_comb begin
    stall = (rs1_used && (rs1 != ZERO_REG) && busy_vec[rs1]) ||
            (rs2_used && (rs2 != ZERO_REG) && busy_vec[rs2]);
  end

  // Completion with nothing outstanding is a protocol error; held until reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_underflow <= 1'b0;
    end else if (complete_valid && (pending_count == '0)) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_scoreboard.sv
module tb_load_scoreboard;

  logic        clk;
  logic        arst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        complete_valid;
  logic [4:0]  rs1;
  logic        rs1_used;
  logic [4:0]  rs2;
  logic        rs2_used;
  logic        stall;
  logic [2:0]  pending_count;
  logic [31:0] busy_vec;
  logic        err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  load_scoreboard dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_ready    (issue_ready),
    .complete_valid (complete_valid),
    .rs1            (rs1),
    .rs1_used       (rs1_used),
    .rs2            (rs2),
    .rs2_used       (rs2_used),
    .stall          (stall),
    .pending_count  (pending_count),
    .busy_vec       (busy_vec),
    .err_underflow  (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        cv;
    logic [4:0]  r1;
    logic        u1;
    logic [4:0]  r2;
    logic        u2;
    logic        e_stall;
    logic        e_rdy;
    logic [2:0]  e_pc;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [4:0] ird, input logic cv,
                     input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic es, input logic er, input logic [2:0] epc,
                     input logic [31:0] eb, input logic ee);
    vec_t v;
    v.iv = iv; v.ird = ird; v.cv = cv; v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2;
    v.e_stall = es; v.e_rdy = er; v.e_pc = epc; v.e_busy = eb; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic es, input logic er,
                           input logic [2:0] epc, input logic [31:0] eb, input logic ee);
    check({tag, ".stall"},         32'(stall),         32'(es));
    check({tag, ".issue_ready"},   32'(issue_ready),   32'(er));
    check({tag, ".pending_count"}, 32'(pending_count), 32'(epc));
    check({tag, ".busy_vec"},      busy_vec,           eb);
    check({tag, ".err_underflow"}, 32'(err_underflow), 32'(ee));
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0; issue_rd = 5'd0; complete_valid = 1'b0;
    rs1 = 5'd0; rs1_used = 1'b0; rs2 = 5'd0; rs2_used = 1'b0;
  endtask

  initial begin
    // Expected values are the outputs seen before the edge that consumes the row's inputs.
    //   iv ird   cv r1    u1 r2    u2   stall rdy pc    busy          err
    // reset idle and load-use on x5
    add(0, 5'd0, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 0);
    add(1, 5'd5, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 0);
    add(0, 5'd0, 0, 5'd5, 1, 5'd0, 0,  1, 1, 3'd1, 32'h0000_0020, 0);
    add(0, 5'd0, 1, 5'd5, 1, 5'd0, 0,  1, 1, 3'd1, 32'h0000_0020, 0);
    add(0, 5'd0, 0, 5'd5, 1, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 0);
    // same rd issued twice
    add(1, 5'd7, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 0);
    add(1, 5'd7, 0, 5'd0, 0, 5'd7, 1,  1, 1, 3'd1, 32'h0000_0080, 0);
    add(0, 5'd0, 1, 5'd0, 0, 5'd7, 1,  1, 1, 3'd2, 32'h0000_0080, 0);
    add(0, 5'd0, 1, 5'd0, 0, 5'd7, 1,  1, 1, 3'd1, 32'h0000_0080, 0);
    add(0, 5'd0, 0, 5'd0, 0, 5'd7, 1,  0, 1, 3'd0, 32'h0000_0000, 0);
    // fill to DEPTH, rejected issue, issue accepted alongside completion
    add(1, 5'd1, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 0);
    add(1, 5'd2, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd1, 32'h0000_0002, 0);
    add(1, 5'd3, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd2, 32'h0000_0006, 0);
    add(1, 5'd4, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd3, 32'h0000_000E, 0);
    add(1, 5'd5, 0, 5'd0, 0, 5'd0, 0,  0, 0, 3'd4, 32'h0000_001E, 0);
    add(1, 5'd9, 1, 5'd0, 0, 5'd0, 0,  0, 1, 3'd4, 32'h0000_001E, 0);
    add(0, 5'd0, 0, 5'd9, 1, 5'd0, 0,  1, 0, 3'd4, 32'h0000_021C, 0);
    add(0, 5'd0, 1, 5'd5, 1, 5'd0, 0,  0, 1, 3'd4, 32'h0000_021C, 0);
    add(0, 5'd0, 1, 5'd0, 0, 5'd0, 0,  0, 1, 3'd3, 32'h0000_0218, 0);
    add(0, 5'd0, 1, 5'd0, 0, 5'd0, 0,  0, 1, 3'd2, 32'h0000_0210, 0);
    add(0, 5'd0, 1, 5'd9, 1, 5'd0, 0,  1, 1, 3'd1, 32'h0000_0200, 0);
    add(0, 5'd0, 0, 5'd9, 1, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 0);
    // x0 destination and unused sources; x0 completes first
    add(1, 5'd0, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 0);
    add(1, 5'd3, 0, 5'd0, 1, 5'd3, 0,  0, 1, 3'd1, 32'h0000_0000, 0);
    add(0, 5'd0, 0, 5'd0, 1, 5'd3, 0,  0, 1, 3'd2, 32'h0000_0008, 0);
    add(0, 5'd0, 1, 5'd0, 0, 5'd3, 1,  1, 1, 3'd2, 32'h0000_0008, 0);
    add(0, 5'd0, 0, 5'd0, 0, 5'd3, 1,  1, 1, 3'd1, 32'h0000_0008, 0);
    add(0, 5'd0, 1, 5'd0, 0, 5'd3, 1,  1, 1, 3'd1, 32'h0000_0008, 0);
    add(0, 5'd0, 0, 5'd0, 0, 5'd3, 1,  0, 1, 3'd0, 32'h0000_0000, 0);
    // underflow is sticky and leaves counts alone
    add(0, 5'd0, 1, 5'd0, 0, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 0);
    add(0, 5'd0, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 1);
    // simultaneous issue and completion of the same rd
    add(1, 5'd6, 0, 5'd0, 0, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 1);
    add(1, 5'd6, 1, 5'd6, 1, 5'd0, 0,  1, 1, 3'd1, 32'h0000_0040, 1);
    add(0, 5'd0, 0, 5'd6, 1, 5'd0, 0,  1, 1, 3'd1, 32'h0000_0040, 1);
    add(0, 5'd0, 1, 5'd0, 0, 5'd0, 0,  0, 1, 3'd1, 32'h0000_0040, 1);
    add(0, 5'd0, 0, 5'd6, 1, 5'd0, 0,  0, 1, 3'd0, 32'h0000_0000, 1);

    drive_idle();
    arst_n = 1'b0;
    #2;
    check_all("in_reset", 1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird; complete_valid = vecs[i].cv;
      rs1 = vecs[i].r1; rs1_used = vecs[i].u1; rs2 = vecs[i].r2; rs2_used = vecs[i].u2;
      @(negedge clk);
      check_all($sformatf("row%0d", i), vecs[i].e_stall, vecs[i].e_rdy,
                vecs[i].e_pc, vecs[i].e_busy, vecs[i].e_err);
    end

    // Asynchronous reset with a load to x8 in flight and the underflow flag set.
    @(posedge clk);
    #1;
    drive_idle();
    issue_valid = 1'b1; issue_rd = 5'd8;
    @(posedge clk);
    #1;
    drive_idle();
    rs1 = 5'd8; rs1_used = 1'b1;
    @(negedge clk);
    check_all("pre_arst", 1'b1, 1'b1, 3'd1, 32'h0000_0100, 1'b1);
    #1;
    arst_n = 1'b0;
    #1;
    check_all("during_arst", 1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_all("post_arst", 1'b0, 1'b1, 3'd0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
